fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, meaning PC loaded at reset and the PC that sequential wrap returns to.
REQ-002 SHALL have parameter MEM_BYTES, default 32, meaning size of byte memory; a multiple of 4.
REQ-003 SHALL have port clk  input  1  clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin fetching from current PC; sampled only in IDLE.
REQ-006 SHALL have port redirect_valid  input  1  replace PC with redirect_pc.
REQ-007 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-008 SHALL have port mem_addr  output  32  byte address to byte memory.
REQ-009 SHALL have port mem_rdata  input  8  byte for the address presented on the previous cycle (fixed 1-cycle read latency).
REQ-010 SHALL have port inst_valid  output  1  inst_data/inst_pc valid.
REQ-011 SHALL have port inst_ready  input  1  consumer accepts word.
REQ-012 SHALL have port inst_data  output  32  assembled instruction, little-endian.
REQ-013 SHALL have port inst_pc  output  32  byte address of inst_data.
REQ-014 SHALL have port busy  output  1  high in FETCH or HOLD.
REQ-015 SHALL have port fault  output  1  high in FAULT.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD, FAULT.
REQ-017 IDLE: start=1 -> FETCH with cnt=0 next cycle; start=0 -> stay.
REQ-018 FETCH: SHALL use a 3-bit counter cnt 0..4; mem_addr = pc + min(cnt,3).
REQ-019 FETCH: at cnt=c (1..4), SHALL capture mem_rdata into inst_data[8(c-1)+7 : 8(c-1)].
REQ-020 FETCH at cnt=4 -> HOLD; inst_valid=1 on the following cycle (5 cycles from FETCH entry to inst_valid).
REQ-021 HOLD: inst_valid=1; inst_data and inst_pc stable while inst_ready=0.
REQ-022 HOLD with inst_ready=1 -> handshake; pc <= pc+4; FETCH cnt=0 next cycle; inst_valid=0 next cycle.
REQ-023 Sequential pc+4 == MEM_BYTES SHALL wrap pc to RESET_PC.
REQ-024 inst_valid SHALL be 0 in IDLE, FETCH and FAULT.
REQ-025 redirect_valid in FETCH or HOLD SHALL abort the current word: in-flight bytes discarded; pc <= redirect_pc; FETCH cnt=0 next cycle; inst_valid=0 next cycle.
REQ-026 redirect_valid in IDLE SHALL load pc and enter FETCH cnt=0, regardless of start.
REQ-027 redirect_valid and inst_ready in the same HOLD cycle: handshake completes (word consumed); next pc = redirect_pc, not pc+4.
REQ-028 Redirect target with redirect_pc[1:0] != 0 or redirect_pc >= MEM_BYTES SHALL enter FAULT instead of FETCH; pc unchanged.
REQ-029 FAULT SHALL be terminal until rst; start, redirect_valid and inst_ready ignored; mem_addr holds its last value.
REQ-030 mem_addr in IDLE SHALL equal pc.
REQ-031 inst_pc SHALL equal the pc used for the FETCH that produced inst_data.

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, pc=RESET_PC, cnt=0, inst_valid=0, inst_data=0, inst_pc=RESET_PC, mem_addr=RESET_PC, busy=0, fault=0.
REQ-033 rst asserted mid-FETCH or mid-HOLD SHALL discard the word; no inst_valid pulse after release until a new start.

Verification
REQ-034 Memory bytes 0..7 = 93 02 00 00 13 03 00 00; start pulse, inst_ready=1 -> inst_valid 5 cycles after FETCH entry, inst_data=0x00000293, inst_pc=0; then 0x00000313, inst_pc=4.
REQ-035 inst_ready=0 for 10 cycles in HOLD -> inst_valid stays 1, inst_data/inst_pc constant, mem_addr unchanged.
REQ-036 Redirect to 24 at FETCH cnt=2 (bytes 24..31 = 6f f0 1f ff 33 05 03 00) -> next word 0xff1ff06f, inst_pc=24; then 0x00030533, inst_pc=28; then wrap to inst_pc=0.
REQ-037 redirect_valid with redirect_pc=6, then with redirect_pc=32 (separate runs) -> fault=1 and busy=0 next cycle; start ignored; rst clears to IDLE.
REQ-038 Same-cycle inst_ready and redirect to 12 in HOLD at pc=0 -> word 0 consumed once; next inst_pc=12, not 4.
REQ-039 rst asserted at FETCH cnt=3 -> all outputs at reset values within the same cycle; no inst_valid until next start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: assembles 32-bit little-endian words from a byte-wide
// memory with fixed 1-cycle read latency, presents them over a valid/ready handshake,
// and supports redirects with alignment/range checking that traps into a terminal FAULT.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        busy,
  output logic        fault
);

  localparam logic [31:0] MemBytesW = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StFault
  } state_e;

  state_e      state;
  logic [31:0] pc;
  logic [2:0]  cnt;
  logic [31:0] addr_hold;

  logic [31:0] pc_seq;
  logic [31:0] addr_off;
  logic [31:0] addr_live;
  logic        redirect_bad;
  logic        can_redirect;

  // Sequential successor wraps back to the reset PC at the end of memory.
  assign pc_seq = ((pc + 32'd4) == MemBytesW) ? RESET_PC : (pc + 32'd4);

  // Misaligned or out-of-range targets trap instead of fetching.
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= MemBytesW);

  assign can_redirect = (state != StFault) && redirect_valid;

  // Byte offset saturates at 3: cnt=4 only collects the last byte, no new address needed.
  assign addr_off  = (cnt > 3'd3) ? 32'd3 : {29'd0, cnt};
  assign addr_live = pc + addr_off;

  // FAULT freezes the memory address at whatever was presented on entry.
  assign mem_addr = (state == StFault) ? addr_hold : addr_live;

  assign busy  = (state == StFetch) || (state == StHold);
  assign fault = (state == StFault);

  // Track the live address so FAULT can keep presenting its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold <= RESET_PC;
    end else if (state != StFault) begin
      addr_hold <= addr_live;
    end
  end

  // Main fetch FSM: state, PC, byte counter and the registered instruction outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      pc         <= RESET_PC;
      cnt        <= 3'd0;
      inst_valid <= 1'b0;
      inst_data  <= 32'h0;
      inst_pc    <= RESET_PC;
    end else if (can_redirect) begin
      // Redirect wins over everything; any in-flight or presented word is dropped
      // (a same-cycle handshake in HOLD still counts as consumed by the consumer).
      inst_valid <= 1'b0;
      cnt        <= 3'd0;
      if (redirect_bad) begin
        state <= StFault;
      end else begin
        pc    <= redirect_pc;
        state <= StFetch;
      end
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            cnt   <= 3'd0;
            state <= StFetch;
          end
        end
        StFetch: begin
          // Data returning now belongs to the address presented at cnt-1.
          unique case (cnt)
            3'd1:    inst_data[7:0]   <= mem_rdata;
            3'd2:    inst_data[15:8]  <= mem_rdata;
            3'd3:    inst_data[23:16] <= mem_rdata;
            3'd4:    inst_data[31:24] <= mem_rdata;
            default: ;
          endcase
          if (cnt == 3'd4) begin
            inst_valid <= 1'b1;
            inst_pc    <= pc;
            state      <= StHold;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        StHold: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            pc         <= pc_seq;
            cnt        <= 3'd0;
            state      <= StFetch;
          end
        end
        StFault: ;
        default: state <= StFault;
      endcase
    end
  end

  // Sanity properties on internal consistency.
  a_cnt_range : assert property (@(posedge clk) disable iff (rst) cnt <= 3'd4);
  a_valid_hold : assert property (@(posedge clk) disable iff (rst)
    inst_valid == (state == StHold));
  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (state == StHold && !inst_ready && !redirect_valid)
      |=> ($stable(inst_data) && $stable(inst_pc)));
  a_fault_sticky : assert property (@(posedge clk) disable iff (rst)
    (state == StFault) |=> (state == StFault));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte memory model, scoreboard of expected words
// checked at every handshake, plus direct checks of reset, hold, fault and latency.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [32];
  logic [63:0] sb [$];
  logic [63:0] mon_exp;

  fetch_sequencer #(
    .RESET_PC  (32'h0),
    .MEM_BYTES (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory with 1-cycle read latency.
  always @(posedge clk) begin
    mem_rdata <= (mem_addr < 32'd32) ? mem[mem_addr[4:0]] : 8'h00;
  end

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word: got data=%h pc=%h, expected no word", inst_data, inst_pc);
      end else begin
        mon_exp = sb.pop_front();
        if ({inst_data, inst_pc} !== mon_exp) begin
          failures++;
          $display("FAIL word: got data=%h pc=%h, expected data=%h pc=%h",
                   inst_data, inst_pc, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles from now until inst_valid rises, bounded.
  task automatic wait_valid(input string nm, output int cyc);
    cyc = 0;
    while (!inst_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!inst_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got inst_valid=0 expected 1 within 50 cycles", nm);
    end
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: got %0d words outstanding expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic seen;

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]  = 8'h93; mem[1]  = 8'h02; mem[2]  = 8'h00; mem[3]  = 8'h00;
    mem[4]  = 8'h13; mem[5]  = 8'h03; mem[6]  = 8'h00; mem[7]  = 8'h00;
    mem[8]  = 8'h01; mem[9]  = 8'h02; mem[10] = 8'h03; mem[11] = 8'h04;
    mem[12] = 8'hb7; mem[13] = 8'h00; mem[14] = 8'h10; mem[15] = 8'h00;
    mem[24] = 8'h6f; mem[25] = 8'hf0; mem[26] = 8'h1f; mem[27] = 8'hff;
    mem[28] = 8'h33; mem[29] = 8'h05; mem[30] = 8'h03; mem[31] = 8'h00;

    // Reset values.
    do_reset();
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Two sequential words with the consumer always ready.
    inst_ready = 1'b1;
    sb.push_back({32'h00000293, 32'h0});
    sb.push_back({32'h00000313, 32'h4});
    pulse_start();
    chk("fetch_entry_busy", {31'd0, busy}, 32'd1);
    wait_valid("first_word", cyc);
    chk("first_word_latency", 32'(cyc), 32'd5);
    wait_empty("seq");

    // Consumer stalls for 10 cycles in HOLD.
    do_reset();
    pulse_start();
    wait_valid("stall", cyc);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!inst_valid || inst_data !== 32'h00000293 || inst_pc !== 32'h0 || mem_addr !== 32'h3)
        seen = 1'b1;
      tick();
    end
    chk("stall_stable", {31'd0, seen}, 32'd0);
    chk("stall_data", inst_data, 32'h00000293);
    chk("stall_addr", mem_addr, 32'h3);
    sb.push_back({32'h00000293, 32'h0});
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_empty("stall");

    // Redirect to 24 mid-fetch, then sequential wrap back to 0.
    do_reset();
    inst_ready = 1'b1;
    sb.push_back({32'hff1ff06f, 32'd24});
    sb.push_back({32'h00030533, 32'd28});
    sb.push_back({32'h00000293, 32'd0});
    pulse_start();
    tick();
    tick();
    chk("cnt2_mem_addr", mem_addr, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd24;
    tick();
    redirect_valid = 1'b0;
    chk("redirect_mem_addr", mem_addr, 32'd24);
    wait_empty("redirect");

    // Bad redirect targets trap; FAULT ignores inputs until reset.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = (r == 0) ? 32'd6 : 32'd32;
      tick();
      redirect_valid = 1'b0;
      chk("fault_set", {31'd0, fault}, 32'd1);
      chk("fault_busy", {31'd0, busy}, 32'd0);
      start          = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd8;
      tick();
      tick();
      tick();
      start          = 1'b0;
      redirect_valid = 1'b0;
      chk("fault_sticky", {31'd0, fault}, 32'd1);
      chk("fault_no_valid", {31'd0, inst_valid}, 32'd0);
      chk("fault_mem_addr", mem_addr, 32'd0);
      rst = 1'b1;
      #1;
      chk("fault_cleared", {31'd0, fault}, 32'd0);
      tick();
      rst = 1'b0;
    end

    // Same-cycle handshake and redirect to 12.
    do_reset();
    pulse_start();
    wait_valid("hs_redirect", cyc);
    sb.push_back({32'h00000293, 32'd0});
    sb.push_back({32'h001000b7, 32'd12});
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd12;
    tick();
    redirect_valid = 1'b0;
    chk("hs_redirect_valid_low", {31'd0, inst_valid}, 32'd0);
    wait_empty("hs_redirect");

    // Asynchronous reset at FETCH cnt=3 discards the partial word.
    do_reset();
    inst_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    tick();
    chk("cnt3_mem_addr", mem_addr, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_data", inst_data, 32'h0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (inst_valid || busy) seen = 1'b1;
      tick();
    end
    chk("no_valid_after_rst", {31'd0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
